ls_quad_access: RTL and testbench
=================================

// Module: ls_quad_access
// PURPOSE
//  Quadword load/store sequencer between the SPU execute pipeline and the
//  32-bit Local Storage memory port. Accepts one 128-bit load or store
//  request and issues four back-to-back 32-bit word accesses to memory.
//  Loads assemble the four words into one 128-bit result, big-endian.
//  Sits directly upstream of the LS memory and drives its memwrite/adr/writedata.
// PARAMETERS
//  WIDTH    32  memory word width and LS address width (bits)
//  QWIDTH   128 quadword (SPU register) width
//  LS_ABITS 14  significant LS byte-address bits (16KB); upper adr bits driven 0
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  reset      in   1       synchronous, active-high
//  req        in   1       request strobe; accepted only when ready=1
//  we         in   1       1=store, 0=load; sampled with req
//  lsaddr     in   WIDTH   byte address; bits [3:0] ignored (quadword aligned)
//  wdata      in   QWIDTH  store data; sampled with req
//  ready      out  1       block can accept req this cycle
//  done       out  1       one-cycle pulse: transfer complete, rdata valid (loads)
//  rdata      out  QWIDTH  load result; holds until next load completes
//  memwrite   out  1       to LS memory: write enable for current word
//  adr        out  WIDTH   to LS memory: byte address of current word
//  writedata  out  WIDTH   to LS memory: store word
//  memdata    in   WIDTH   from LS memory: word at adr, combinational read
// BEHAVIOUR
//  - States: IDLE, XFER (beat 0..3), DONE. Reset -> IDLE, beat=0, rdata=0,
//    done=0, ready=1, memwrite=0, adr=0, writedata=0.
//  - IDLE: ready=1. On req: latch base={lsaddr[LS_ABITS-1:4],4'b0}, we, wdata;
//    next state XFER, beat=0. No req: stay IDLE.
//  - XFER: adr = (base + 4*beat) masked to LS_ABITS; zero-extended to WIDTH.
//    Store: memwrite=1, writedata=wdata_q[QWIDTH-1-32*beat -: 32] (beat0 = MSW).
//    Load: memwrite=0; at posedge capture memdata into
//    rdata_q[QWIDTH-1-32*beat -: 32]. beat increments; after beat 3 -> DONE.
//  - rdata port updates only when the load completes (staging reg copied on
//    entry to DONE); a store never alters rdata.
//  - DONE: done=1 for exactly one cycle, ready=1. req accepted here behaves as
//    in IDLE (next state XFER); else -> IDLE.
//  - Latency: req accepted at edge N -> beats in cycles N+1..N+4 -> done high in
//    cycle N+5. Min accept-to-accept interval 5 cycles (accept in DONE).
//  - req while ready=0: ignored, no side effect; requester must hold/retry.
//  - Outside XFER: memwrite=0, adr=0, writedata=0.
//  - Address wrap: base 0x3FF0 yields words 0x3FF0,0x3FF4,0x3FF8,0x3FFC; the
//    4-bit aligned base cannot cross 16KB within a quadword; mask still applied.
//  - Reset mid-transfer: memwrite forced 0 combinationally while reset=1 (no
//    write commits on the reset edge); partial load discarded, rdata=0,
//    done not pulsed; IDLE next cycle.
//  - memwrite, adr, writedata are combinational from state/beat/latched regs;
//    no combinational path from req/lsaddr/wdata to the memory port.
// STRUCTURE
//  - Shared package spu_ls_pkg: state encoding (IDLE/XFER/DONE), QW_BYTES=16,
//    BEATS=4, LS_ABITS default.
//  - Single module; beat counter and word-slice mux inline. No sub-module.
// TESTING
//  - Store: req, we=1, lsaddr=0x0100, wdata=0x00112233_44556677_8899AABB_CCDDEEFF
//    -> memwrite=1 for 4 cycles at adr 0x100/104/108/10C writing 00112233,
//    44556677,8899AABB,CCDDEEFF; done pulse cycle N+5.
//  - Load back 0x0100 -> rdata=0x00112233_44556677_8899AABB_CCDDEEFF at done,
//    memwrite never asserted.
//  - Misaligned: load lsaddr=0x0107 -> accesses 0x100..0x10C, same rdata as above.
//  - Top of LS: store at 0x3FF0 then load 0x3FF0 -> round-trip match; adr never
//    exceeds 0x3FFC.
//  - Back-to-back: req held high with load 0x100 then store 0x200 -> second
//    accepted in DONE, adr 0x200 in cycle N+6; req in XFER ignored (no extra done).
//  - Reset asserted during beat 2 of store to 0x300 -> only words 0x300,0x304
//    written, 0x308/0x30C unchanged; no done; ready=1 and rdata=0 after reset.

Source files
------------

// File: rtl/spu_ls_pkg.sv
// Shared constants for the SPU local-storage quadword sequencer:
// FSM state encoding, quadword geometry and the default LS address width.
package spu_ls_pkg;

  // FSM state encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Quadword geometry: 16 bytes moved as four 32-bit beats
  localparam int QW_BYTES = 16;
  localparam int BEATS    = 4;
  localparam int QW_LSB   = $clog2(QW_BYTES);
  localparam int BEAT_W   = $clog2(BEATS);

  // Default LS size: 16KB byte-addressed
  localparam int LS_ABITS_DEF = 14;

endpackage : spu_ls_pkg

// File: rtl/ls_quad_access.sv
// Quadword load/store sequencer. One accepted 128-bit request becomes four
// back-to-back 32-bit accesses on the LS memory port, most significant word
// first. Loads are staged and published to rdata only when all four beats
// have landed, so rdata always holds a complete quadword.
module ls_quad_access
  import spu_ls_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int QWIDTH   = 128,
  parameter int LS_ABITS = LS_ABITS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [WIDTH-1:0]  lsaddr,
  input  logic [QWIDTH-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [QWIDTH-1:0] rdata,
  output logic              memwrite,
  output logic [WIDTH-1:0]  adr,
  output logic [WIDTH-1:0]  writedata,
  input  logic [WIDTH-1:0]  memdata
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [1:0]             state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [LS_ABITS-1:0]    base_q;
  logic                   we_q;
  logic [QWIDTH-1:0]      wdata_q;
  logic [QWIDTH-WIDTH-1:0] stage_q;   // first three load words, shifted in
  logic [QWIDTH-1:0]      rdata_q;

  logic                   in_xfer;
  logic                   accept;
  logic                   last_beat;
  logic [BEAT_W-1:0]      wsel;       // word index within quadword, 0 = LSW
  logic [LS_ABITS-1:0]    word_adr;

  // Address bits outside the LS window and inside the quadword are don't-care
  logic unused_lsaddr;
  assign unused_lsaddr = ^{lsaddr[WIDTH-1:LS_ABITS], lsaddr[QW_LSB-1:0]};

  assign in_xfer   = (state_q == S_XFER);
  assign ready     = !in_xfer;
  assign done      = (state_q == S_DONE);
  assign accept    = req && ready;
  assign last_beat = (beat_q == LAST_BEAT);
  assign wsel      = LAST_BEAT - beat_q;
  assign word_adr  = base_q + LS_ABITS'({beat_q, 2'b00});
  assign rdata     = rdata_q;

  // Memory port: purely from registered state; write gated by reset so a
  // transfer interrupted by reset never commits a word on the reset edge
  always_comb begin
    memwrite  = 1'b0;
    adr       = '0;
    writedata = '0;
    if (in_xfer) begin
      memwrite  = we_q && !reset;
      adr       = WIDTH'(word_adr);
      writedata = wdata_q[wsel*WIDTH +: WIDTH];
    end
  end

  // Next state and beat counter
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        beat_d  = '0;
        state_d = req ? S_XFER : S_IDLE;
      end
      S_XFER: begin
        if (last_beat) begin
          state_d = S_DONE;
          beat_d  = '0;
        end else begin
          beat_d  = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Request capture, load staging and publication of completed loads
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      stage_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        base_q  <= {lsaddr[LS_ABITS-1:QW_LSB], {QW_LSB{1'b0}}};
        we_q    <= we;
        wdata_q <= wdata;
      end
      if (in_xfer && !we_q) begin
        if (last_beat)
          rdata_q <= {stage_q, memdata};
        else
          stage_q <= {stage_q[QWIDTH-2*WIDTH-1:0], memdata};
      end
    end
  end

endmodule : ls_quad_access

// File: tb/tb_ls_quad_access.sv
// Directed bench for ls_quad_access with a small behavioural LS memory.
module tb_ls_quad_access;

  logic         clk = 1'b0;
  logic         reset, req, we;
  logic [31:0]  lsaddr;
  logic [127:0] wdata;
  logic         ready, done, memwrite;
  logic [127:0] rdata;
  logic [31:0]  adr, writedata, memdata;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [31:0] max_adr = '0;

  logic [31:0] mem [4096];

  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D2 = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
  localparam logic [127:0] D3 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
  localparam logic [127:0] D4 = 128'h11111111_22222222_33333333_44444444;

  ls_quad_access dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .lsaddr(lsaddr),
    .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
    .memwrite(memwrite), .adr(adr), .writedata(writedata), .memdata(memdata)
  );

  always #5 clk = ~clk;

  // LS memory: combinational read, write on posedge
  assign memdata = mem[adr[13:2]];
  always @(posedge clk) if (memwrite) mem[adr[13:2]] <= writedata;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;
  always @(negedge clk) if (adr > max_adr) max_adr <= adr;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 | i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] wrd(input logic [127:0] d, input int b);
    logic [127:0] t;
    t = d;
    return t[127-32*b -: 32];
  endfunction

  task automatic test_reset;
    reset = 1; req = 0; we = 0; lsaddr = '0; wdata = '0;
    tick; tick;
    reset = 0;
    #1;
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0h want 1", ready); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0h want 0", done); end
    n_chk++; if (rdata !== 128'h0) begin n_fail++; $display("FAIL reset_rdata got %0h want 0", rdata); end
    n_chk++; if (memwrite !== 1'b0) begin n_fail++; $display("FAIL reset_memwrite got %0h want 0", memwrite); end
    n_chk++; if (adr !== 32'h0) begin n_fail++; $display("FAIL reset_adr got %0h want 0", adr); end
    n_chk++; if (writedata !== 32'h0) begin n_fail++; $display("FAIL reset_writedata got %0h want 0", writedata); end
  endtask

  task automatic test_store;
    req = 1; we = 1; lsaddr = 32'h0100; wdata = D1;
    tick;
    req = 0; wdata = '0;
    for (int b = 0; b < 4; b++) begin
      n_chk++; if (memwrite !== 1'b1) begin n_fail++; $display("FAIL store_memwrite b%0d got %0h want 1", b, memwrite); end
      n_chk++; if (adr !== 32'h100 + 4*b) begin n_fail++; $display("FAIL store_adr b%0d got %0h want %0h", b, adr, 32'h100 + 4*b); end
      n_chk++; if (writedata !== wrd(D1, b)) begin n_fail++; $display("FAIL store_wdata b%0d got %0h want %0h", b, writedata, wrd(D1, b)); end
      n_chk++; if (ready !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL store_busy b%0d got ready=%0h done=%0h want 0 0", b, ready, done); end
      tick;
    end
    n_chk++; if (done !== 1'b1 || ready !== 1'b1) begin n_fail++; $display("FAIL store_done got done=%0h ready=%0h want 1 1", done, ready); end
    n_chk++; if (rdata !== 128'h0) begin n_fail++; $display("FAIL store_rdata_kept got %0h want 0", rdata); end
    n_chk++; if (memwrite !== 1'b0 || adr !== 32'h0) begin n_fail++; $display("FAIL store_port_idle got mw=%0h adr=%0h want 0 0", memwrite, adr); end
    tick;
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL store_done_pulse got %0h want 0", done); end
    for (int b = 0; b < 4; b++) begin
      n_chk++; if (mem[64 + b] !== wrd(D1, b)) begin n_fail++; $display("FAIL store_mem b%0d got %0h want %0h", b, mem[64 + b], wrd(D1, b)); end
    end
  endtask

  task automatic test_load;
    req = 1; we = 0; lsaddr = 32'h0100;
    tick;
    req = 0;
    for (int b = 0; b < 4; b++) begin
      n_chk++; if (memwrite !== 1'b0) begin n_fail++; $display("FAIL load_memwrite b%0d got %0h want 0", b, memwrite); end
      n_chk++; if (adr !== 32'h100 + 4*b) begin n_fail++; $display("FAIL load_adr b%0d got %0h want %0h", b, adr, 32'h100 + 4*b); end
      if (b == 2) begin
        n_chk++; if (rdata !== 128'h0) begin n_fail++; $display("FAIL load_rdata_early got %0h want 0", rdata); end
      end
      tick;
    end
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL load_done got %0h want 1", done); end
    n_chk++; if (rdata !== D1) begin n_fail++; $display("FAIL load_rdata got %0h want %0h", rdata, D1); end
    tick;
  endtask

  task automatic test_misaligned;
    req = 1; we = 0; lsaddr = 32'h0107;
    tick;
    req = 0;
    for (int b = 0; b < 4; b++) begin
      n_chk++; if (adr !== 32'h100 + 4*b) begin n_fail++; $display("FAIL misal_adr b%0d got %0h want %0h", b, adr, 32'h100 + 4*b); end
      tick;
    end
    n_chk++; if (done !== 1'b1 || rdata !== D1) begin n_fail++; $display("FAIL misal_rdata got done=%0h rdata=%0h want 1 %0h", done, rdata, D1); end
    tick;
  endtask

  task automatic test_top_of_ls;
    max_adr = '0;
    req = 1; we = 1; lsaddr = 32'h3FF0; wdata = D2;
    tick;
    req = 0;
    for (int b = 0; b < 4; b++) begin
      n_chk++; if (adr !== 32'h3FF0 + 4*b || memwrite !== 1'b1) begin n_fail++; $display("FAIL top_st_adr b%0d got adr=%0h mw=%0h want %0h 1", b, adr, memwrite, 32'h3FF0 + 4*b); end
      tick;
    end
    tick;
    // upper address bits above the LS window are ignored
    req = 1; we = 0; lsaddr = 32'h0001_FFF5;
    tick;
    req = 0;
    for (int b = 0; b < 4; b++) begin
      n_chk++; if (adr !== 32'h3FF0 + 4*b) begin n_fail++; $display("FAIL top_ld_adr b%0d got %0h want %0h", b, adr, 32'h3FF0 + 4*b); end
      tick;
    end
    n_chk++; if (done !== 1'b1 || rdata !== D2) begin n_fail++; $display("FAIL top_rdata got done=%0h rdata=%0h want 1 %0h", done, rdata, D2); end
    n_chk++; if (max_adr !== 32'h3FFC) begin n_fail++; $display("FAIL top_max_adr got %0h want 3ffc", max_adr); end
    tick;
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = done_cnt;
    req = 1; we = 0; lsaddr = 32'h0100;
    tick;                                   // accepted at edge N
    for (int b = 0; b < 4; b++) begin
      n_chk++; if (adr !== 32'h100 + 4*b || memwrite !== 1'b0) begin n_fail++; $display("FAIL b2b_ld b%0d got adr=%0h mw=%0h want %0h 0", b, adr, memwrite, 32'h100 + 4*b); end
      if (b == 2) begin we = 1; lsaddr = 32'h0200; wdata = D3; end
      tick;
    end
    n_chk++; if (done !== 1'b1 || rdata !== D1) begin n_fail++; $display("FAIL b2b_ld_done got done=%0h rdata=%0h want 1 %0h", done, rdata, D1); end
    tick;                                   // cycle N+6
    req = 0;
    for (int b = 0; b < 4; b++) begin
      n_chk++; if (adr !== 32'h200 + 4*b || memwrite !== 1'b1 || writedata !== wrd(D3, b)) begin n_fail++; $display("FAIL b2b_st b%0d got adr=%0h mw=%0h wd=%0h want %0h 1 %0h", b, adr, memwrite, writedata, 32'h200 + 4*b, wrd(D3, b)); end
      tick;
    end
    n_chk++; if (done !== 1'b1 || rdata !== D1) begin n_fail++; $display("FAIL b2b_st_done got done=%0h rdata=%0h want 1 %0h", done, rdata, D1); end
    tick; tick;
    n_chk++; if (done_cnt !== d0 + 2) begin n_fail++; $display("FAIL b2b_done_count got %0d want %0d", done_cnt, d0 + 2); end
    n_chk++; if (mem[131] !== wrd(D3, 3)) begin n_fail++; $display("FAIL b2b_mem got %0h want %0h", mem[131], wrd(D3, 3)); end
  endtask

  task automatic test_reset_mid;
    int d0;
    d0 = done_cnt;
    req = 1; we = 1; lsaddr = 32'h0300; wdata = D4;
    tick;
    req = 0;
    tick; tick;                             // beats 0 and 1 written
    n_chk++; if (adr !== 32'h308 || memwrite !== 1'b1) begin n_fail++; $display("FAIL rmid_beat2 got adr=%0h mw=%0h want 308 1", adr, memwrite); end
    reset = 1;
    #1;
    n_chk++; if (memwrite !== 1'b0) begin n_fail++; $display("FAIL rmid_mw_gated got %0h want 0", memwrite); end
    tick;
    reset = 0;
    #1;
    n_chk++; if (ready !== 1'b1 || done !== 1'b0 || rdata !== 128'h0) begin n_fail++; $display("FAIL rmid_state got ready=%0h done=%0h rdata=%0h want 1 0 0", ready, done, rdata); end
    n_chk++; if (memwrite !== 1'b0 || adr !== 32'h0) begin n_fail++; $display("FAIL rmid_port got mw=%0h adr=%0h want 0 0", memwrite, adr); end
    tick; tick; tick; tick;
    n_chk++; if (done_cnt !== d0) begin n_fail++; $display("FAIL rmid_no_done got %0d want %0d", done_cnt, d0); end
    n_chk++; if (mem[192] !== wrd(D4, 0) || mem[193] !== wrd(D4, 1)) begin n_fail++; $display("FAIL rmid_written got %0h %0h want %0h %0h", mem[192], mem[193], wrd(D4, 0), wrd(D4, 1)); end
    n_chk++; if (mem[194] !== 32'h5A00_00C2 || mem[195] !== 32'h5A00_00C3) begin n_fail++; $display("FAIL rmid_untouched got %0h %0h want 5a0000c2 5a0000c3", mem[194], mem[195]); end
  endtask

  initial begin
    test_reset;
    test_store;
    test_load;
    test_misaligned;
    test_top_of_ls;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_ls_quad_access
